// File: rtl/mem_port_arbiter.sv
// Arbitrates one blocking memory port between instruction fetch and the data side.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that aborts with bus_err after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          ICacheMiss,
    input  logic          d_req,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          DCacheMiss,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          bus_err
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} arbStateT;

    arbStateT state;
    logic     lastGrantD;
    logic     grantD;
    logic     grantI;

    // On a tie the side that did not win the previous tie goes first.
    assign grantD = d_req & (~i_req | ~lastGrantD);
    assign grantI = i_req & ~grantD;

    assign ICacheMiss = i_req & ~i_done;
    assign DCacheMiss = d_req & ~d_done;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CntW-1:0] busyCnt;
    logic            timedOut;

    assign timedOut = (busyCnt == CntW'(TIMEOUT - 1));
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            lastGrantD <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            busyCnt    <= '0;
            bus_err    <= 1'b0;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (i_req && d_req) begin
                        lastGrantD <= grantD;
                    end
                    if (grantD) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_wdata <= d_wdata;
                        state     <= StBusyD;
                    end else if (grantI) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= i_addr;
                        mem_we    <= '0;
                        mem_wdata <= '0;
                        state     <= StBusyI;
                    end
`ifdef ARB_TIMEOUT_EN
                    busyCnt <= '0;
`endif
                end
                StBusyI, StBusyD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= StDone;
                        if (state == StBusyI) begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timedOut) begin
                        mem_req <= 1'b0;
                        state   <= StDone;
                        bus_err <= 1'b1;
                        if (state == StBusyI) begin
                            i_rdata <= DW'(32'hDEADBEEF);
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= DW'(32'hDEADBEEF);
                            d_done  <= 1'b1;
                        end
                    end else begin
                        busyCnt <= busyCnt + 1'b1;
                    end
`endif
                end
                // Requests are deliberately not sampled here.
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, multi-cycle unified memory between the instruction-fetch side (IF) and the data side (MEM-WB) of the RV32 pipeline.
- Sequences one blocking transaction at a time with a req/ack handshake on the memory side.
- Drives per-side stall outputs, which feed the ICacheMiss/DCacheMiss inputs of the hazard unit.
- Returns read data with a one-cycle done pulse.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-low
i_req  in  1  fetch request; held until i_done
i_addr  in  AW  fetch address
i_rdata  out  DW  fetched word; registered
i_done  out  1  one-cycle completion pulse, fetch side
ICacheMiss  out  1  fetch stall = i_req & ~i_done
d_req  in  1  data request; held until d_done
d_we  in  4  byte write enables; 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  loaded word; registered
d_done  out  1  one-cycle completion pulse, data side
DCacheMiss  out  1  data stall = d_req & ~d_done
mem_req  out  1  memory request; registered
mem_addr  out  AW  memory address; registered
mem_we  out  4  memory byte enables; registered
mem_wdata  out  DW  memory write data; registered
mem_ack  in  1  memory completion; valid only while mem_req=1
mem_rdata  in  DW  memory read data; valid with mem_ack
bus_err  out  1  timeout abort flag (pulses with done)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; last_grant=I, so D wins the first tie.
  - All registered outputs are 0: mem_req, mem_addr, mem_we, mem_wdata, i_rdata, d_rdata, i_done, d_done, bus_err.
  - Reset mid-transaction drops mem_req immediately; no done pulse is issued.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Only one requester: grant it.
  - Both requesting: grant the side NOT in last_grant (alternating fairness); update last_grant.
  - On grant, the next edge loads mem_addr/mem_we/mem_wdata from the granted side. mem_we=0 and mem_wdata=0 for fetches.
  - Same edge sets mem_req=1 and moves to BUSY_I or BUSY_D.
- BUSY_x:
  - mem_req and mem_* stay stable until mem_ack.
  - On mem_ack: mem_req goes to 0, mem_rdata is captured into x_rdata (stores also capture; value is don't-care to the core), x_done is set to 1, and the state moves to DONE.
- DONE:
  - x_done is high for exactly this cycle, then the state returns to IDLE.
  - Requests are not sampled in DONE, so a stalled stage advancing on done cannot be re-granted for the same access.
- Minimum latency: req at cycle 0 → mem_req at cycle 1 → ack at cycle 1 → done at cycle 2 (2 cycles when memory acks immediately).
- Requester dropping req mid-transaction (e.g. pipeline flush): the transaction still completes and done still pulses. The stall output is already 0 because req=0.
- Stall outputs are combinational; all other outputs are registered.
- rdata registers hold their value until the next completion on that side.
- mem_ack outside BUSY is ignored.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit+ counter clears on entry to BUSY_x and increments each BUSY cycle.
  - Reaching TIMEOUT without mem_ack aborts: mem_req=0, x_rdata=32'hDEADBEEF, x_done=1, bus_err=1 in the same DONE cycle.
- Undefined: no counter; BUSY waits indefinitely; bus_err is tied 0.

Test Plan:
- Reset during BUSY_D with mem_req=1 → mem_req=0 asynchronously; no d_done; after release state=IDLE and all outputs 0.
- Fetch only: i_req=1, i_addr=0x100, mem acks 3 cycles after mem_req with 0x00000013 → mem_addr=0x100, mem_we=0; i_done pulses once; i_rdata=0x13; ICacheMiss high until the done cycle.
- Simultaneous i_req and d_req after reset (d_we=4'hF, d_addr=0x2000, d_wdata=0xCAFEBABE), immediate acks → D granted first; mem_we=4'hF, mem_wdata=0xCAFEBABE; then I granted; next tie grants I first.
- Load: d_we=0, d_addr=0x2004, mem_rdata=0x12345678 on ack → d_rdata=0x12345678; DCacheMiss=0 in the d_done cycle; held req is not re-granted in DONE.
- Flush: drop i_req while BUSY_I → transaction completes on ack; i_done pulses; ICacheMiss stays 0.
- With ARB_TIMEOUT_EN, TIMEOUT=4, no ack → abort after 4 BUSY cycles; d_rdata=0xDEADBEEF; bus_err and d_done pulse together.
